// File: rtl/or1200_dcpu_sram_pkg.sv
// Shared constants for the dcpu SRAM responder: FSM state encoding and the
// OR1200 data-tag values driven back to the LSU.
package or1200_dcpu_sram_pkg;

    localparam logic [1:0] st_idle = 2'd0;
    localparam logic [1:0] st_wait = 2'd1;
    localparam logic [1:0] st_ack  = 2'd2;
    localparam logic [1:0] st_err  = 2'd3;

    localparam logic [3:0] OR1200_DTAG_IDLE = 4'h0;
    localparam logic [3:0] OR1200_DTAG_ND   = 4'h1;
    localparam logic [3:0] OR1200_DTAG_BE   = 4'hb;

    // Counter start value for a given wait-state count; 0 wait states never load it.
    function automatic logic [3:0] wait_load(input int wait_states);
        return (wait_states <= 0) ? 4'd0 : 4'(wait_states - 1);
    endfunction

endpackage

// File: rtl/or1200_dcpu_sram_ram.sv
// Single-port 2^aw x 32 SRAM, synchronous read, per-byte write enables
// (we[3] writes bits 31:24).
module or1200_dcpu_sram_ram #(
    parameter int aw = 10
) (
    input  logic          clk,
    input  logic          ce,
    input  logic [3:0]    we,
    input  logic [aw-1:0] addr,
    input  logic [31:0]   din,
    output logic [31:0]   dout
);

    logic [31:0] mem [2**aw];

    always_ff @(posedge clk) begin
        if (ce) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][i*8 +: 8] <= din[i*8 +: 8];
            end
            if (we == 4'b0000) dout <= mem[addr];
        end
    end

endmodule

// File: rtl/or1200_dcpu_sram.sv
// dcpu-port responder terminating LSU loads/stores into a local SRAM window
// after WAIT retry cycles.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   st_idle | no request in progress
//   st_wait | hit accepted, counting down wait states (rty high)
//   st_ack  | one-cycle completion; RAM access committed on entry
//   st_err  | one-cycle bus error for a miss or empty byte select
module or1200_dcpu_sram
    import or1200_dcpu_sram_pkg::*;
#(
    parameter int          aw   = 10,
    parameter logic [31:0] BASE = 32'h0000_0000,
    parameter int          WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dcpu_adr_i,
    input  logic        dcpu_cycstb_i,
    input  logic        dcpu_we_i,
    input  logic [3:0]  dcpu_sel_i,
    input  logic [3:0]  dcpu_tag_i,
    input  logic [31:0] dcpu_dat_i,
    output logic [31:0] dcpu_dat_o,
    output logic        dcpu_ack_o,
    output logic        dcpu_rty_o,
    output logic        dcpu_err_o,
    output logic [3:0]  dcpu_tag_o
);

    logic [1:0]  state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic        hit, commit, load_q;
    logic [31:0] ram_q;
    logic        unused_inputs;

    assign unused_inputs = ^{dcpu_tag_i, dcpu_adr_i[1:0]};

    assign hit = (dcpu_adr_i[31:aw+2] == BASE[31:aw+2]) && (dcpu_sel_i != 4'b0000);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            st_idle: begin
                if (dcpu_cycstb_i) begin
                    if (!hit) begin
                        state_nxt = st_err;
                    end else if (WAIT == 0) begin
                        state_nxt = st_ack;
                    end else begin
                        state_nxt = st_wait;
                        cnt_nxt   = wait_load(WAIT);
                    end
                end
            end
            st_wait: begin
                if (!dcpu_cycstb_i) begin
                    state_nxt = st_idle;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = st_ack;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: state_nxt = st_idle;
        endcase
    end

    // Reset in the same cycle suppresses the commit, so no write can leak through.
    assign commit = (state_nxt == st_ack) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= st_idle;
            cnt    <= 4'd0;
            load_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) load_q <= !dcpu_we_i;
        end
    end

    or1200_dcpu_sram_ram #(.aw(aw)) u_ram (
        .clk  (clk),
        .ce   (commit),
        .we   (dcpu_we_i ? dcpu_sel_i : 4'b0000),
        .addr (dcpu_adr_i[aw+1:2]),
        .din  (dcpu_dat_i),
        .dout (ram_q)
    );

    assign dcpu_ack_o = (state == st_ack);
    assign dcpu_err_o = (state == st_err);
    assign dcpu_rty_o = dcpu_cycstb_i && !dcpu_ack_o && !dcpu_err_o;
    assign dcpu_dat_o = (dcpu_ack_o && load_q) ? ram_q : 32'h0;
    assign dcpu_tag_o = dcpu_err_o ? OR1200_DTAG_BE : OR1200_DTAG_IDLE;

endmodule

// File: tb/tb_or1200_dcpu_sram.sv
// Directed bench for or1200_dcpu_sram: three instances (WAIT = 1, 3, 0) driven
// in sequence; expected completions are queued at request time and popped on ack/err.
module tb_or1200_dcpu_sram;

    localparam int waits [3] = '{1, 3, 0};

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr   [3];
    logic        cyc   [3];
    logic        we    [3];
    logic [3:0]  sel   [3];
    logic [31:0] dat_i [3];
    logic [31:0] dat_o [3];
    logic        ack   [3];
    logic        rty   [3];
    logic        err   [3];
    logic [3:0]  tag_o [3];

    typedef struct packed {
        logic        err;
        logic [31:0] dat;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    or1200_dcpu_sram #(.aw(10), .BASE(32'h0), .WAIT(1)) u_w1 (
        .clk(clk), .rst(rst), .dcpu_adr_i(adr[0]), .dcpu_cycstb_i(cyc[0]),
        .dcpu_we_i(we[0]), .dcpu_sel_i(sel[0]), .dcpu_tag_i(4'h1),
        .dcpu_dat_i(dat_i[0]), .dcpu_dat_o(dat_o[0]), .dcpu_ack_o(ack[0]),
        .dcpu_rty_o(rty[0]), .dcpu_err_o(err[0]), .dcpu_tag_o(tag_o[0])
    );

    or1200_dcpu_sram #(.aw(10), .BASE(32'h0), .WAIT(3)) u_w3 (
        .clk(clk), .rst(rst), .dcpu_adr_i(adr[1]), .dcpu_cycstb_i(cyc[1]),
        .dcpu_we_i(we[1]), .dcpu_sel_i(sel[1]), .dcpu_tag_i(4'h1),
        .dcpu_dat_i(dat_i[1]), .dcpu_dat_o(dat_o[1]), .dcpu_ack_o(ack[1]),
        .dcpu_rty_o(rty[1]), .dcpu_err_o(err[1]), .dcpu_tag_o(tag_o[1])
    );

    or1200_dcpu_sram #(.aw(10), .BASE(32'h0), .WAIT(0)) u_w0 (
        .clk(clk), .rst(rst), .dcpu_adr_i(adr[2]), .dcpu_cycstb_i(cyc[2]),
        .dcpu_we_i(we[2]), .dcpu_sel_i(sel[2]), .dcpu_tag_i(4'h1),
        .dcpu_dat_i(dat_i[2]), .dcpu_dat_o(dat_o[2]), .dcpu_ack_o(ack[2]),
        .dcpu_rty_o(rty[2]), .dcpu_err_o(err[2]), .dcpu_tag_o(tag_o[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0;
            we[i]  = 1'b0;
        end
    endtask

    // Drive one request starting in the next cycle; returns after the ack/err cycle
    // with cycstb still high, so a following call is back-to-back.
    task automatic access(input string tag, input int d, input logic [31:0] a,
                          input logic w, input logic [3:0] s, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_rd);
        exp_t e;
        exp_t x;
        logic done;
        e.err = exp_err;
        e.dat = (exp_err || w) ? 32'h0 : exp_rd;
        e.lat = exp_err ? 8'd1 : 8'(waits[d] + 1);
        sb.push_back(e);
        @(posedge clk); #1;
        cyc[d] = 1'b1; adr[d] = a; we[d] = w; sel[d] = s; dat_i[d] = wd;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (ack[d] || err[d]) begin
                x = sb.pop_front();
                chk({tag, ".lat"},  32'(c), 32'(x.lat));
                chk({tag, ".kind"}, {30'h0, ack[d], err[d]}, {30'h0, !x.err, x.err});
                chk({tag, ".dat"},  dat_o[d], x.dat);
                chk({tag, ".tag"},  {28'h0, tag_o[d]}, x.err ? 32'hb : 32'h0);
                chk({tag, ".rty_done"}, {31'h0, rty[d]}, 32'h0);
                done = 1'b1;
            end else begin
                chk({tag, ".rty"}, {31'h0, rty[d]}, 32'h1);
            end
        end
        chk({tag, ".timeout"}, {31'h0, done}, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc[i] = 1'b0; we[i] = 1'b0; sel[i] = 4'h0; adr[i] = 32'h0; dat_i[i] = 32'h0;
        end
        cyc[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset.ack", {31'h0, ack[i]}, 32'h0);
            chk("reset.err", {31'h0, err[i]}, 32'h0);
            chk("reset.dat", dat_o[i], 32'h0);
            chk("reset.tag", {28'h0, tag_o[i]}, 32'h0);
            chk("reset.rty", {31'h0, rty[i]}, (i == 0) ? 32'h1 : 32'h0);
        end
        @(posedge clk); #1;
        cyc[0] = 1'b0;
        rst    = 1'b0;

        // WAIT=1: word, byte and halfword stores, loads, misses
        access("w1.st_word", 0, 32'h10, 1'b1, 4'b1111, 32'hDEADBEEF, 1'b0, 32'h0);
        idle();
        access("w1.ld_word", 0, 32'h10, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hDEADBEEF);
        idle();
        access("w1.st_byte", 0, 32'h11, 1'b1, 4'b0100, 32'h00AB0000, 1'b0, 32'h0);
        idle();
        access("w1.ld_byte", 0, 32'h10, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hDEABBEEF);
        idle();
        access("w1.st_half", 0, 32'h12, 1'b1, 4'b0011, 32'h0000CAFE, 1'b0, 32'h0);
        idle();
        access("w1.ld_half", 0, 32'h10, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hDEABCAFE);
        idle();
        access("w1.st_zero", 0, 32'h0, 1'b1, 4'b1111, 32'h12345678, 1'b0, 32'h0);
        idle();
        access("w1.st_top", 0, 32'hFFC, 1'b1, 4'b1111, 32'hC0FFEE11, 1'b0, 32'h0);
        idle();
        access("w1.miss_st", 0, 32'h4000, 1'b1, 4'b1111, 32'hFFFFFFFF, 1'b1, 32'h0);
        idle();
        access("w1.miss_ld", 0, 32'h8000_0010, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0);
        idle();
        access("w1.ld_zero", 0, 32'h0, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h12345678);
        idle();
        access("w1.ld_top", 0, 32'hFFC, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hC0FFEE11);
        idle();
        access("w1.sel0", 0, 32'h10, 1'b1, 4'b0000, 32'h55555555, 1'b1, 32'h0);
        idle();
        access("w1.ld_after_err", 0, 32'h10, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hDEABCAFE);
        idle();

        // WAIT=3: abort mid-wait, then reset mid-wait
        access("w3.st_init", 1, 32'h20, 1'b1, 4'b1111, 32'h11111111, 1'b0, 32'h0);
        idle();
        @(posedge clk); #1;
        cyc[1] = 1'b1; adr[1] = 32'h20; we[1] = 1'b1; sel[1] = 4'b1111; dat_i[1] = 32'h22222222;
        @(negedge clk);
        chk("w3.abort.rty0", {31'h0, rty[1]}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("w3.abort.rty1", {31'h0, rty[1]}, 32'h1);
        @(posedge clk); #1;
        cyc[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("w3.abort.ack_err", {30'h0, ack[1], err[1]}, 32'h0);
        end
        access("w3.ld_after_abort", 1, 32'h20, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11111111);
        idle();

        @(posedge clk); #1;
        cyc[1] = 1'b1; adr[1] = 32'h20; we[1] = 1'b1; sel[1] = 4'b1111; dat_i[1] = 32'h33333333;
        @(posedge clk); #1;
        rst    = 1'b1;
        cyc[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("w3.rst.ack", {31'h0, ack[1]}, 32'h0);
        chk("w3.rst.err", {31'h0, err[1]}, 32'h0);
        chk("w3.rst.rty", {31'h0, rty[1]}, 32'h0);
        chk("w3.rst.dat", dat_o[1], 32'h0);
        chk("w3.rst.tag", {28'h0, tag_o[1]}, 32'h0);
        access("w3.ld_after_rst", 1, 32'h20, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h11111111);
        idle();

        // WAIT=0: setup stores, then back-to-back loads
        access("w0.st_a", 2, 32'h40, 1'b1, 4'b1111, 32'hA5A5A5A5, 1'b0, 32'h0);
        idle();
        access("w0.st_b", 2, 32'h44, 1'b1, 4'b1111, 32'h5A5A5A5A, 1'b0, 32'h0);
        idle();
        access("w0.ld_a", 2, 32'h40, 1'b0, 4'b1111, 32'h0, 1'b0, 32'hA5A5A5A5);
        access("w0.ld_b", 2, 32'h44, 1'b0, 4'b1111, 32'h0, 1'b0, 32'h5A5A5A5A);
        idle();
        access("w0.miss", 2, 32'h1000, 1'b0, 4'b1111, 32'h0, 1'b1, 32'h0);
        idle();
        access("w0.ld_after_miss", 2, 32'h40, 1'b0, 4'b1000, 32'h0, 1'b0, 32'hA5A5A5A5);
        idle();

        chk("sb.empty", 32'(sb.size()), 32'h0);
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/or1200_dcpu_sram.md
# or1200_dcpu_sram

Data-side responder for the OR1200 data CPU interface (dcpu_*). It terminates load/store requests from the LSU into a local byte-writable SRAM window. It inserts a configurable number of wait states, signalled by retry, and then completes each request with a one-cycle ack or a bus-error pulse. It sits where the data cache or the data bus bridge would normally hang off the dcpu port, and serves as a tightly coupled data memory or a verification target.

## Interface
- aw, 10, word-index width; window size is 4·2^aw bytes
- BASE, 32'h0000_0000, window base address, aligned to 4·2^aw
- WAIT, 1, wait states before completion, range 0..15
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- dcpu_adr_i  in  32  byte address
- dcpu_cycstb_i  in  1  request valid
- dcpu_we_i  in  1  1 = store
- dcpu_sel_i  in  4  byte lanes, big-endian: 4'b1000 = byte at adr[1:0]=00 = bits 31:24
- dcpu_tag_i  in  4  request tag (OR1200_DTAG_ND when active); ignored
- dcpu_dat_i  in  32  store data, already lane-aligned
- dcpu_dat_o  out  32  load data
- dcpu_ack_o  out  1  completion pulse
- dcpu_rty_o  out  1  request pending; the LSU stalls on it
- dcpu_err_o  out  1  bus-error pulse
- dcpu_tag_o  out  4  OR1200_DTAG_BE with err, otherwise OR1200_DTAG_IDLE

## Operation
- **Hit:** adr[31:aw+2] == BASE[31:aw+2] and sel != 0. Anything else with cycstb high is a miss.
- **States:** IDLE, WAIT, ACK, ERR.
- **IDLE**
  - cycstb & miss → ERR.
  - cycstb & hit & WAIT==0 → ACK.
  - cycstb & hit & WAIT>0 → WAIT, with cnt = WAIT-1.
- **WAIT**
  - ~cycstb → IDLE (abort; no write, no ack).
  - cnt==0 → ACK.
  - Otherwise cnt decrements.
- **ACK and ERR:** last exactly one cycle, then go to IDLE unconditionally.
- **Commit edge:** the edge entering ACK.
  - Stores write the lanes selected by sel into mem[adr[aw+1:2]], using the inputs as sampled at that edge.
  - Loads issue a synchronous read at the same edge. Read-before-write does not arise, since one request is committed at a time.
- **Output values**
  - dcpu_ack_o = (state==ACK).
  - dcpu_err_o = (state==ERR).
  - dcpu_rty_o = dcpu_cycstb_i & ~ack_o & ~err_o (combinational).
  - dcpu_dat_o = RAM output during ACK of a load; 0 otherwise.
- **Request attributes:** adr, we, sel and dat must be held stable by the initiator while the request is pending. Only the values at the commit edge matter.

## Timing
- **Reset:**
  - state=IDLE, cnt=0; ack_o=0, err_o=0, dat_o=0, tag_o=IDLE.
  - rty_o follows cycstb_i.
  - RAM contents are not reset.
- **Hit latency:** request first seen at cycle 0 → ack at cycle WAIT+1; rty high cycles 0..WAIT.
- **Miss latency:** err plus tag BE at cycle 1; rty high at cycle 0 only.
- **Back-to-back:** a new request can be accepted in the cycle after ACK or ERR. Peak throughput is one access every WAIT+2 cycles.
- **Abort:** dropping cycstb in IDLE or WAIT leaves no side effects. Dropping it during ACK or ERR changes nothing; the commit has already happened.
- **rst mid-operation:** return to IDLE on the next edge. Any pending write is discarded.
- **cnt:** 4 bits, never wraps; it only decrements from WAIT-1 down to 0.

## Structure
- **Shared package/defines:** state encoding (2 bits). The DTAG values reuse the existing OR1200_DTAG_* defines.
- **Sub-module or1200_dcpu_sram_ram:** single-port, 2^aw × 32, synchronous read, per-byte write enables (we[3] → bits 31:24).
- **Top level:** contains the FSM, the wait counter, the hit decode and the output muxing.

## Test plan
- **Word store then load, WAIT=1:** store 0xDEADBEEF to 0x10 with sel 1111.
  - rty in cycles 0–1, ack in cycle 2.
  - A load of 0x10 then returns 0xDEADBEEF in its ack cycle.
- **Byte store:** store 0x00AB0000 to 0x11 with sel 0100.
  - A word load of 0x10 returns 0xDEABBEEF.
- **Out of window:** access 0x4000 with aw=10, BASE=0.
  - err and tag_o=BE in cycle 1, no ack; RAM unchanged.
  - sel=0000 inside the window also gives err.
- **Abort with WAIT=3:** drop cycstb in cycle 2 of a store.
  - No ack; a later load shows the old data.
- **WAIT=0, back-to-back loads:** ack in cycle 1, IDLE in cycle 2, second ack in cycle 3. rty is high only in each request's first cycle.
- **Reset during WAIT:** assert rst in cycle 1.
  - All outputs are 0 in the next cycle and no write happens.
  - A later request completes normally.
